lcd_hex_formatter: RTL and testbench
====================================

# lcd_hex_formatter

Upstream feeder for the character LCD controller. Accepts 16-bit values from the processor datapath with a field index, and converts each value to four ASCII hex characters. Emits them one per clock on the controller's `writeEnable`/`location`/`data` character-write port. A small request FIFO absorbs bursts so the datapath rarely stalls.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: request FIFO entries; must be a power of two and at least 2.
- `LEADING_ZERO_BLANK`, default 0: when 1, leading zero digits are emitted as space (0x20). The last digit is never blanked.

Ports:
- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; equals `~full & ~reset`.
- `req_field`  in  3  display field, 0–7. Fields 0–3 are line 1; fields 4–7 are line 2.
- `req_value`  in  16  value to display.
- `writeEnable`  out  1  character write strobe to the LCD controller.
- `location`  out  5  character cell, equal to `{field, digit_idx[1:0]}`.
- `data`  out  8  ASCII character.
- `busy`  out  1  high when the FIFO is non-empty or the state is EMIT.

## Operation
- **Accept:** a request is accepted on an edge where `req_valid & req_ready`. Field and value are pushed into the FIFO.
- **FSM states:** IDLE and EMIT, with a 2-bit `digit_idx`.
  - IDLE → EMIT when the FIFO is non-empty. The head is popped into `cur_field`/`cur_value` and `digit_idx` is set to 0.
  - In EMIT, `digit_idx` increments each cycle.
  - At `digit_idx == 3`: if the FIFO is non-empty, pop the next head and restart at `digit_idx = 0` with no bubble; otherwise go to IDLE.
- **Digit order:** MSB first. `digit_idx` 0 takes `value[15:12]`, 1 takes `[11:8]`, 2 takes `[7:4]`, 3 takes `[3:0]`.
- **ASCII mapping:** nibble n < 10 gives 0x30 + n; n ≥ 10 gives 0x37 + n (uppercase A–F).
- **Blanking** (only when `LEADING_ZERO_BLANK=1`): digits 0–2 output 0x20 while every nibble from digit 0 up to and including the current one is zero. Digit 3 is always converted.
- **Outputs:**
  - In EMIT, driven combinationally from the registered state: `writeEnable=1`, `location={cur_field, digit_idx}`, `data`=converted char.
  - In IDLE: `writeEnable=0`, `location=0`, `data=0`.
- **Reset values:** state IDLE, FIFO empty, `digit_idx=0`, `writeEnable=0`, `location=0`, `data=0`, `busy=0`, `req_ready=0` while reset is asserted.
- **FIFO full:** `req_ready=0`. No push occurs on a full FIFO even if a pop happens on the same edge; there is no combinational ready-from-pop path.
- **Reset mid-operation:** the current request and all FIFO contents are discarded. `writeEnable` is 0 in the cycle after the reset edge, and partially written fields are not completed.
- **Same-field requests:** queued requests to the same field are emitted in order; the last one wins on the display.

## Timing
- A request accepted at edge N is popped at edge N+1 if the FSM is idle.
- Digit 0 is driven in cycle N+1→N+2, and digits 1–3 follow on the next three cycles. Minimum latency from accept to first write is 1 cycle.
- No same-edge bypass: an entry pushed at edge N cannot be popped at edge N.
- Back-to-back requests produce a continuous `writeEnable` (4k consecutive cycles for k requests).
- Sustained throughput is one request per 4 cycles. `req_ready` deasserts after the FIFO fills: FIFO_DEPTH entries plus one in flight.

## Structure
- **Shared package `lcd_pkg`:**
  - `ASCII_ZERO`=8'h30, `ASCII_ALPHA_OFS`=8'h37, `ASCII_SPACE`=8'h20.
  - State enum {IDLE, EMIT}.
  - `LCD_CELLS`=32, `FIELD_W`=3.
- **Sub-module `lcd_req_fifo`:** synchronous FIFO, 19 bits wide, with `FIFO_DEPTH` entries. It uses registered read/write pointers with an extra wrap bit, and exposes `full`/`empty`.
- The nibble-to-ASCII conversion is a function in `lcd_pkg`.

## Test plan
- **Single request:** after reset, push field=0, value=16'h1A3F with `LEADING_ZERO_BLANK=0` → writes (0,0x31), (1,0x41), (2,0x33), (3,0x46) on 4 consecutive cycles starting 1 cycle after accept; then `busy=0`.
- **Back-to-back, second line:** push field=5 value=16'h00C0, then field=7 value=16'hFFFF on consecutive cycles → 8 consecutive strobes at locations 20–23 then 28–31 with data 30,30,43,30,46,46,46,46; no gap.
- **Blanking:** `LEADING_ZERO_BLANK=1`, value=16'h0000 gives 20,20,20,30; value=16'h0105 gives 20,31,30,35.
- **Full FIFO:** hold `req_valid=1` with 10 distinct values, FIFO_DEPTH=4 → `req_ready` falls after 5 accepts. All 10 requests are emitted in order, none lost or duplicated, with a scoreboard check on location/data.
- **Reset mid-operation:** assert reset during digit 1 of a request with 2 more queued → `writeEnable=0` the next cycle, `busy=0`, and no further writes after reset is released until a new request arrives.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encoding and the nibble-to-ASCII helper
// used by the LCD hex formatter and its request FIFO.
//   ASCII_*     : character codes used when building hex digits
//   lcd_state_e : formatter FSM states (IDLE, EMIT)
//   REQ_W       : width of one queued request {field, value}
package lcd_pkg;

    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;
    localparam logic [7:0] ASCII_SPACE     = 8'h20;

    localparam int LCD_CELLS = 32;
    localparam int FIELD_W   = 3;
    localparam int VALUE_W   = 16;
    localparam int REQ_W     = FIELD_W + VALUE_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } lcd_state_e;

    // 0-9 map onto '0'..'9'; 10-15 map onto 'A'..'F' (0x37 + 10 = 0x41).
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = ASCII_ZERO + {4'd0, nib};
        end else begin
            ch = ASCII_ALPHA_OFS + {4'd0, nib};
        end
        return ch;
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// lcd_req_fifo: synchronous request FIFO for the LCD hex formatter.
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter. DEPTH must be a power of two, >= 2.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data when not full (ignored when full)
//   pop        : advance the read pointer when not empty
//   pop_data   : current head entry (valid while empty is low)
//   full/empty : occupancy flags, purely from registered pointers
module lcd_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with different wrap bits means the writer lapped the reader.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/lcd_hex_formatter.sv
// lcd_hex_formatter: turns queued 16-bit values into four ASCII hex
// characters, written MSB digit first, one per clock, to the LCD
// controller character port.
//   clk, reset   : clock, synchronous active-high reset
//   req_valid    : request present        req_ready : FIFO can accept
//   req_field    : display field 0-7      req_value : value to show
//   writeEnable  : character write strobe
//   location     : {field, digit index}   data      : ASCII character
//   busy         : FIFO non-empty or a value is being emitted
//   dbg_state    : current FSM state (0 = IDLE, 1 = EMIT)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on registered FIFO
// fullness and reset, never on a same-cycle pop, and req_valid may be held
// high while req_ready is low without any effect.
module lcd_hex_formatter
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH         = 4,
    parameter int LEADING_ZERO_BLANK = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_field,
    input  logic [15:0] req_value,
    output logic        writeEnable,
    output logic [4:0]  location,
    output logic [7:0]  data,
    output logic        busy,
    output logic        dbg_state
);

    localparam logic [0:0] STATE_IDLE = IDLE;
    localparam logic [0:0] STATE_EMIT = EMIT;

    logic [0:0]         state_q, state_d;
    logic [1:0]         digit_idx_q, digit_idx_d;
    logic [2:0]         cur_field_q, cur_field_d;
    logic [15:0]        cur_value_q, cur_value_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REQ_W-1:0]   fifo_head;

    logic               emitting;
    logic [3:0]         nibble;
    logic [3:0]         lead_zero;
    logic               blank;
    logic [7:0]         char_out;

    assign req_ready = ~fifo_full & ~reset;
    assign fifo_push = req_valid & req_ready;

    lcd_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({req_field, req_value}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-request load happens both from IDLE and on the last digit of
    // EMIT, so back-to-back requests stream without a bubble.
    always_comb begin
        state_d     = state_q;
        digit_idx_d = digit_idx_q;
        cur_field_d = cur_field_q;
        cur_value_d = cur_value_q;
        fifo_pop    = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    state_d     = STATE_EMIT;
                    digit_idx_d = 2'd0;
                    cur_field_d = fifo_head[REQ_W-1:VALUE_W];
                    cur_value_d = fifo_head[VALUE_W-1:0];
                end
            end
            STATE_EMIT: begin
                if (digit_idx_q == 2'd3) begin
                    digit_idx_d = 2'd0;
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        cur_field_d = fifo_head[REQ_W-1:VALUE_W];
                        cur_value_d = fifo_head[VALUE_W-1:0];
                    end else begin
                        state_d = STATE_IDLE;
                    end
                end else begin
                    digit_idx_d = digit_idx_q + 2'd1;
                end
            end
            default: begin
                state_d     = STATE_IDLE;
                digit_idx_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            digit_idx_q <= 2'd0;
            cur_field_q <= 3'd0;
            cur_value_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            digit_idx_q <= digit_idx_d;
            cur_field_q <= cur_field_d;
            cur_value_q <= cur_value_d;
        end
    end

    always_comb begin
        nibble = 4'd0;
        case (digit_idx_q)
            2'd0:    nibble = cur_value_q[15:12];
            2'd1:    nibble = cur_value_q[11:8];
            2'd2:    nibble = cur_value_q[7:4];
            default: nibble = cur_value_q[3:0];
        endcase
    end

    // lead_zero[i]: every nibble from digit 0 through digit i is zero.
    // Bit 3 is tied low so the final digit is always converted.
    assign lead_zero[0] = (cur_value_q[15:12] == 4'd0);
    assign lead_zero[1] = lead_zero[0] & (cur_value_q[11:8] == 4'd0);
    assign lead_zero[2] = lead_zero[1] & (cur_value_q[7:4] == 4'd0);
    assign lead_zero[3] = 1'b0;

    assign blank    = (LEADING_ZERO_BLANK != 0) && lead_zero[digit_idx_q];
    assign char_out = blank ? ASCII_SPACE : nibble_to_ascii(nibble);

    assign emitting    = (state_q == STATE_EMIT);
    assign writeEnable = emitting;
    assign location    = emitting ? {cur_field_q, digit_idx_q} : 5'd0;
    assign data        = emitting ? char_out : 8'd0;
    assign busy        = ~fifo_empty | emitting;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lcd_hex_formatter.sv
// Bench for lcd_hex_formatter: two instances (blanking off / on) driven by
// the same request stream, each with its own expected-write queue.
module tb_lcd_hex_formatter;

  localparam int W = 13;  // {location[4:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req_valid = 1'b0;
  logic [2:0]  req_field = 3'd0;
  logic [15:0] req_value = 16'd0;

  logic        ready_p, we_p, busy_p, dbg_p;
  logic [4:0]  loc_p;
  logic [7:0]  data_p;
  logic        ready_b, we_b, busy_b, dbg_b;
  logic [4:0]  loc_b;
  logic [7:0]  data_b;

  lcd_hex_formatter #(.FIFO_DEPTH(4), .LEADING_ZERO_BLANK(0)) u_dut_plain (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_p),
    .req_field(req_field), .req_value(req_value), .writeEnable(we_p),
    .location(loc_p), .data(data_p), .busy(busy_p), .dbg_state(dbg_p)
  );

  lcd_hex_formatter #(.FIFO_DEPTH(4), .LEADING_ZERO_BLANK(1)) u_dut_blank (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_b),
    .req_field(req_field), .req_value(req_value), .writeEnable(we_b),
    .location(loc_b), .data(data_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_p_q[$];
  logic [W-1:0] exp_b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Four expected writes per request, chars packed digit 0 in the top byte.
  task automatic expect_req(input logic [2:0] f, input logic [31:0] plain, input logic [31:0] blnk);
    for (int d = 0; d < 4; d++) begin
      logic [1:0] di;
      di = d[1:0];
      exp_p_q.push_back({f, di, plain[31-8*d -: 8]});
      exp_b_q.push_back({f, di, blnk[31-8*d -: 8]});
    end
  endtask

  // Reference conversion via a character lookup table.
  function automatic logic [31:0] hex_model(input logic [15:0] v, input bit blank_en);
    string digits;
    logic [31:0] r;
    logic [3:0] nib;
    bit lead;
    digits = "0123456789ABCDEF";
    lead = 1'b1;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      nib = v[15-4*d -: 4];
      if (blank_en && lead && nib == 4'd0 && d < 3) begin
        r[31-8*d -: 8] = 8'h20;
      end else begin
        r[31-8*d -: 8] = digits[nib];
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Monitor: every strobe must match the head of that instance's queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (we_p) begin
        if (exp_p_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL plain_unexpected_write: got loc=%0d data=%h, required no write", loc_p, data_p);
        end else begin
          check("plain_write", {19'd0, loc_p, data_p}, {19'd0, exp_p_q.pop_front()});
        end
      end
      if (we_b) begin
        if (exp_b_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL blank_unexpected_write: got loc=%0d data=%h, required no write", loc_b, data_b);
        end else begin
          check("blank_write", {19'd0, loc_b, data_b}, {19'd0, exp_b_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_p_q.delete();
    exp_b_q.delete();
    reset = 1'b0;
  endtask

  // Presents one request and returns #1 after the edge that accepted it.
  task automatic send(input logic [2:0] f, input logic [15:0] v);
    int g;
    req_field = f;
    req_value = v;
    req_valid = 1'b1;
    g = 0;
    while (!ready_p && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) check("send_ready_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy_p || busy_b) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({name, "_idle_timeout"}, {31'd0, g >= 200}, 32'd0);
    check({name, "_queues_drained"}, exp_p_q.size() + exp_b_q.size(), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  field;
    logic [15:0] value;
    logic [31:0] exp_plain;
    logic [31:0] exp_blank;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] burst_vals[10];

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int writes;

    vecs[0] = '{3'd0, 16'h1A3F, 32'h31413346, 32'h31413346};
    vecs[1] = '{3'd3, 16'h0000, 32'h30303030, 32'h20202030};
    vecs[2] = '{3'd4, 16'h0105, 32'h30313035, 32'h20313035};
    vecs[3] = '{3'd6, 16'hBEEF, 32'h42454546, 32'h42454546};
    vecs[4] = '{3'd1, 16'h0009, 32'h30303039, 32'h20202039};
    vecs[5] = '{3'd7, 16'h00C0, 32'h30304330, 32'h20204330};
    vecs[6] = '{3'd2, 16'hF000, 32'h46303030, 32'h46303030};
    vecs[7] = '{3'd5, 16'h0010, 32'h30303130, 32'h20203130};

    burst_vals = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0F0F,
                   16'h00A0, 16'h7000, 16'h0001, 16'hFEDC, 16'h0000};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_plain", {18'd0, we_p, loc_p, data_p, busy_p, ready_p}, 32'd0);
    check("reset_outputs_blank", {18'd0, we_b, loc_b, data_b, busy_b, ready_b}, 32'd0);
    do_reset();
    @(negedge clk);
    check("ready_after_reset", {30'd0, ready_p, ready_b}, 32'd3);
    check("state_after_reset", {30'd0, dbg_p, dbg_b}, 32'd0);

    // ---- table: single requests, with first-write latency ----
    for (int i = 0; i < 8; i++) begin
      expect_req(vecs[i].field, vecs[i].exp_plain, vecs[i].exp_blank);
      send(vecs[i].field, vecs[i].value);
      @(negedge clk);
      check("latency_no_write_cycle0", {30'd0, we_p, busy_p}, 32'd1);
      @(negedge clk);
      check("latency_first_write", {25'd0, we_p, dbg_p, loc_p}, {25'd0, 1'b1, 1'b1, vecs[i].field, 2'b00});
      wait_idle("vector");
      check("idle_after_vector", {29'd0, we_p, busy_p, dbg_p}, 32'd0);
    end

    // ---- back-to-back on line 2: 8 continuous strobes ----
    expect_req(3'd5, 32'h30304330, 32'h20204330);
    expect_req(3'd7, 32'h46464646, 32'h46464646);
    send(3'd5, 16'h00C0);
    send(3'd7, 16'hFFFF);
    run = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (we_p && we_b && k == run) run++;
    end
    check("b2b_continuous_strobes", run, 32'd8);
    wait_idle("b2b");

    // ---- full FIFO with req_valid held high ----
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int g;
      logic [2:0] f;
      f = i[2:0];
      req_field = f;
      req_value = burst_vals[i];
      g = 0;
      while (!ready_p && g < 100) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (g >= 100) check("burst_ready_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      expect_req(f, hex_model(burst_vals[i], 1'b0), hex_model(burst_vals[i], 1'b1));
      if (i < 5) check("burst_ready_after_accept", {31'd0, ready_p}, {31'd0, i != 4});
    end
    req_valid = 1'b0;
    wait_idle("burst");

    // ---- reset during digit 1 with two more queued ----
    req_valid = 1'b1;
    req_field = 3'd2;
    req_value = 16'h1234;
    @(posedge clk);  // A accepted
    #1;
    exp_p_q.push_back({3'd2, 2'd0, 8'h31});
    exp_b_q.push_back({3'd2, 2'd0, 8'h31});
    req_field = 3'd3;
    req_value = 16'h5678;
    @(posedge clk);  // B accepted, A popped
    #1;
    req_field = 3'd4;
    req_value = 16'h9ABC;
    @(posedge clk);  // C accepted, A digit 1 now driven
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_digit1_driven", {26'd0, we_p, loc_p}, {26'd0, 1'b1, 3'd2, 2'd1});
    check("midreset_ready_low", {30'd0, ready_p, ready_b}, 32'd0);
    check("midreset_digit0_seen", exp_p_q.size() + exp_b_q.size(), 32'd0);
    @(posedge clk);  // reset edge
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_quiet", {28'd0, we_p, we_b, busy_p, busy_b}, 32'd0);
    writes = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (we_p || we_b) writes++;
    end
    check("after_reset_no_writes", writes, 32'd0);
    expect_req(3'd6, 32'h30304646, 32'h20204646);
    send(3'd6, 16'h00FF);
    wait_idle("recovery");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
